// File: rtl/shift_mix_columns.sv
// AES-128 ShiftRows + MixColumns round stage, one column per clock through a single shared MixColumns unit.
// Latency 4 cycles from accept to o_valid; no accept while busy, result held in DONE until i_ready.
module shift_mix_columns #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_last_round,
    input  logic [DATA_WIDTH-1:0] i_s0,
    input  logic [DATA_WIDTH-1:0] i_s1,
    input  logic [DATA_WIDTH-1:0] i_s2,
    input  logic [DATA_WIDTH-1:0] i_s3,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_out0,
    output logic [DATA_WIDTH-1:0] o_out1,
    output logic [DATA_WIDTH-1:0] o_out2,
    output logic [DATA_WIDTH-1:0] o_out3,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic [1:0]                     col;
    logic                           last_q;
    logic [3:0][DATA_WIDTH-1:0]     st_q;
    logic [3:0][DATA_WIDTH-1:0]     out_q;
    logic [DATA_WIDTH-1:0]          sh_col;
    logic [DATA_WIDTH-1:0]          mix_col;
    logic [DATA_WIDTH-1:0]          res_col;
    logic                           accept;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_one(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = a[7:0];
        a1 = a[15:8];
        a2 = a[23:16];
        a3 = a[31:24];
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b3, b2, b1, b0};
    endfunction

    assign accept = i_valid && o_ready;

    // ShiftRows for the column under the counter: row r comes from column (col+r) mod 4.
    always_comb begin
        sh_col = '0;
        for (int r = 0; r < 4; r++) begin
            sh_col[8*r +: 8] = st_q[col + 2'(r)][8*r +: 8];
        end
    end

    assign mix_col = mix_one(sh_col);
    assign res_col = last_q ? sh_col : mix_col;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            col    <= 2'd0;
            last_q <= 1'b0;
            st_q   <= '0;
            out_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                st_q   <= {i_s3, i_s2, i_s1, i_s0};
                last_q <= i_last_round;
                col    <= 2'd0;
            end
            if (state == CALC) begin
                out_q[col] <= res_col;
                col        <= col + 2'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        o_busy    = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_nxt = CALC;
            end
            CALC: begin
                o_busy = 1'b1;
                if (col == 2'd3) state_nxt = DONE;
            end
            DONE: begin
                o_busy  = 1'b1;
                o_valid = 1'b1;
                if (i_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_out0 = out_q[0];
    assign o_out1 = out_q[1];
    assign o_out2 = out_q[2];
    assign o_out3 = out_q[3];

endmodule

// File: tb/tb_shift_mix_columns.sv
// Bench for shift_mix_columns: scoreboard of reference-model results, checked when o_valid is seen.
module tb_shift_mix_columns;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_last_round;
    logic [31:0] i_s0, i_s1, i_s2, i_s3;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_out0, o_out1, o_out2, o_out3;
    logic        o_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] V1   = {32'h3052411e, 32'he55db4b8, 32'hf198bfe0, 32'hae1127d4};
    localparam logic [127:0] EXP1 = {32'h4c260628, 32'h7ad3f848, 32'h9a19cbe0, 32'he5816604};
    localparam logic [127:0] EXPL = {32'he598271e, 32'hf11141b8, 32'hae52b4e0, 32'h305dbfd4};
    localparam logic [127:0] V80  = {4{32'h80808080}};

    shift_mix_columns #(.DATA_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_last_round(i_last_round), .i_s0(i_s0), .i_s1(i_s1), .i_s2(i_s2), .i_s3(i_s3),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_out0(o_out0), .o_out1(o_out1), .o_out2(o_out2), .o_out3(o_out3), .o_busy(o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    // Generic GF(2^8) shift-and-add multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input bit last);
        logic [7:0]   a[4][4];
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                a[c][r] = s[32*((c + r) % 4) + 8*r +: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[32*c + 8*r +: 8] = last ? a[c][r] :
                    gmul(a[c][r], 8'd2) ^ gmul(a[c][(r+1)%4], 8'd3) ^ a[c][(r+2)%4] ^ a[c][(r+3)%4];
        return res;
    endfunction

    function automatic logic [127:0] outs();
        return {o_out3, o_out2, o_out1, o_out0};
    endfunction

    // Drive one state for a single cycle from a negedge; the last-round flag flips afterwards on purpose.
    task automatic send(input logic [127:0] s, input bit last);
        {i_s3, i_s2, i_s1, i_s0} = s;
        i_last_round = last;
        i_valid      = 1'b1;
        exp_q.push_back(model(s, last));
        @(negedge i_clk);
        i_valid      = 1'b0;
        i_last_round = ~last;
    endtask

    task automatic wait_valid(output int lat, output bit to);
        lat = 0;
        to  = 1'b0;
        while (!o_valid) begin
            if (lat >= 20) begin
                to = 1'b1;
                break;
            end
            @(negedge i_clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", o_ready); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", o_valid); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", o_busy); end
        total++; if (outs() !== 128'h0) begin bad++; $display("FAIL rst_outs: got %h want 0", outs()); end
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_vector(input string tag, input logic [127:0] s, input bit last, input logic [127:0] golden);
        int lat;
        bit to;
        logic [127:0] e;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_pre: got %b want 1", tag, o_ready); end
        send(s, last);
        total++; if ({o_busy, o_ready} !== 2'b10) begin bad++; $display("FAIL %s_busy: got %b want 10", tag, {o_busy, o_ready}); end
        wait_valid(lat, to);
        total++;
        if (to) begin bad++; $display("FAIL %s_timeout: got no o_valid want o_valid within 20 cycles", tag); end
        else if (lat !== 4) begin bad++; $display("FAIL %s_latency: got %0d want 4", tag, lat); end
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL %s_sb_empty: got empty queue want entry", tag); end
        else begin
            e = exp_q.pop_front();
            if (outs() !== e) begin bad++; $display("FAIL %s_sb: got %h want %h", tag, outs(), e); end
        end
        total++; if (outs() !== golden) begin bad++; $display("FAIL %s_golden: got %h want %h", tag, outs(), golden); end
        @(negedge i_clk);
        total++; if ({o_valid, o_ready, o_busy} !== 3'b010) begin bad++; $display("FAIL %s_idle_after: got %b want 010", tag, {o_valid, o_ready, o_busy}); end
        total++; if (outs() !== golden) begin bad++; $display("FAIL %s_hold_after: got %h want %h", tag, outs(), golden); end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        int errs;
        logic [127:0] e;
        i_ready = 1'b0;
        send(V1, 1'b0);
        wait_valid(lat, to);
        total++; if (to || lat !== 4) begin bad++; $display("FAIL bp_latency: got %0d (timeout %0b) want 4", lat, to); end
        e = (exp_q.size() != 0) ? exp_q[0] : 128'hx;
        errs = 0;
        for (int t = 0; t < 10; t++) begin
            if (t == 3) begin
                {i_s3, i_s2, i_s1, i_s0} = V80;
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            if ({o_valid, o_ready, o_busy} !== 3'b101 || outs() !== e) begin
                errs++;
                $display("FAIL bp_hold_%0d: got v/r/b=%b out=%h want 101 out=%h", t, {o_valid, o_ready, o_busy}, outs(), e);
            end
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        total++; if (errs != 0) bad++;
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL bp_sb_empty: got empty queue want entry"); end
        else begin
            e = exp_q.pop_front();
            if (outs() !== e) begin bad++; $display("FAIL bp_sb: got %h want %h", outs(), e); end
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        total++; if ({o_valid, o_ready, o_busy} !== 3'b010) begin bad++; $display("FAIL bp_release: got %b want 010", {o_valid, o_ready, o_busy}); end
        errs = 0;
        repeat (6) begin
            @(negedge i_clk);
            if (o_busy !== 1'b0 || o_valid !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL bp_ignored_pulse: got %0d busy cycles want 0", errs); end
    endtask

    task automatic test_reset_mid();
        int errs;
        send(V1, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        total++; if ({o_ready, o_valid, o_busy} !== 3'b100) begin bad++; $display("FAIL rm_ctrl: got %b want 100", {o_ready, o_valid, o_busy}); end
        total++; if (outs() !== 128'h0) begin bad++; $display("FAIL rm_outs: got %h want 0", outs()); end
        exp_q.delete();
        errs = 0;
        repeat (6) begin
            @(negedge i_clk);
            if (o_valid !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL rm_no_valid: got %0d valid cycles want 0", errs); end
        test_vector("rm_fresh", V1, 1'b0, EXP1);
    endtask

    task automatic test_back_to_back();
        int acc[2];
        int nacc;
        int nres;
        int sent;
        logic [127:0] vb;
        logic [127:0] e;
        vb = {32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};
        acc[0] = 0;
        acc[1] = 0;
        nacc = 0;
        nres = 0;
        {i_s3, i_s2, i_s1, i_s0} = V1;
        i_last_round = 1'b0;
        i_valid = 1'b1;
        exp_q.push_back(model(V1, 1'b0));
        sent = 1;
        for (int t = 0; t < 60 && nres < 2; t++) begin
            if (i_valid && o_ready && nacc < 2) begin
                acc[nacc] = cyc + 1;
                nacc++;
            end
            @(negedge i_clk);
            if (nacc == 1 && sent == 1) begin
                {i_s3, i_s2, i_s1, i_s0} = vb;
                exp_q.push_back(model(vb, 1'b0));
                sent = 2;
            end
            if (nacc == 2) i_valid = 1'b0;
            if (o_valid) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_sb_empty: got empty queue want entry"); end
                else begin
                    e = exp_q.pop_front();
                    if (outs() !== e) begin bad++; $display("FAIL b2b_sb_%0d: got %h want %h", nres, outs(), e); end
                end
                nres++;
            end
        end
        i_valid = 1'b0;
        total++; if (nres != 2) begin bad++; $display("FAIL b2b_results: got %0d want 2", nres); end
        total++; if (nacc != 2 || acc[1] - acc[0] != 6) begin bad++; $display("FAIL b2b_interval: got %0d accepts gap %0d want 2 gap 6", nacc, acc[1] - acc[0]); end
        @(negedge i_clk);
    endtask

    initial begin
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_last_round = 1'b0;
        {i_s3, i_s2, i_s1, i_s0} = '0;
        @(negedge i_clk);
        test_reset();
        test_vector("round1", V1, 1'b0, EXP1);
        test_vector("last", V1, 1'b1, EXPL);
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_vector("xtime", V80, 1'b0, V80);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
